// File: rtl/udp_line_receiver.sv
// udp_line_receiver: SFD hunt, Eth/IPv4/UDP header filter, one video line per datagram as pixel writes.
// Latency: pix_valid one cycle after the B byte; line_done/line_err one cycle after rx_valid drops.
// No backpressure: a byte is consumed every rx_valid cycle. UDP_LINE_RECEIVER_FCS_EN adds an FCS check.
module udp_line_receiver #(
  parameter int unsigned H_ACT      = 1280,
  parameter int unsigned V_ACT      = 720,
  parameter logic [47:0] LOCAL_MAC  = 48'h000A_3501_FEC0,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [23:0] pix_data,
  output logic        line_done,
  output logic        line_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, LINE_NO, PIXEL, TAIL, DROP
  } state_t;

  localparam logic [11:0] X_LAST = 12'(H_ACT - 1);
  localparam logic [15:0] V_LIM  = 16'(V_ACT);

  state_t      state_q, state_d;
  logic        rx_valid_prev_q, rx_valid_prev_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic        mac_uni_q, mac_uni_d;
  logic        mac_bc_q, mac_bc_d;
  logic [7:0]  line_hi_q, line_hi_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic [11:0] col_q, col_d;
  logic        reached_pix_q, reached_pix_d;

  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_x_q, pix_x_d;
  logic [11:0] pix_y_q, pix_y_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        line_done_q, line_done_d;
  logic        line_err_q, line_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        fcs_good;
  logic [7:0]  mac_byte;
  logic        uni_ok, bc_ok, hdr_ok;
  logic [15:0] line_idx;
  logic        drop_inc;

`ifdef UDP_LINE_RECEIVER_FCS_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Register is re-seeded while hunting so it covers exactly the bytes after SFD, FCS included.
  always_comb begin
    crc_d = crc_q;
    if (state_q == PREAMBLE) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (rx_valid) begin
      crc_d = crc_byte(crc_q, rx_data);
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign fcs_good = (crc_q == 32'hDEBB_20E3);
`else
  assign fcs_good = 1'b1;
`endif

  // Header byte filter; MAC bytes track unicast and broadcast matches in parallel.
  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
    uni_ok = mac_uni_q && (rx_data == mac_byte);
    bc_ok  = mac_bc_q && (rx_data == 8'hFF);
    hdr_ok = 1'b1;
    case (byte_cnt_q)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: hdr_ok = uni_ok || bc_ok;
      6'd12:   hdr_ok = (rx_data == 8'h08);
      6'd13:   hdr_ok = (rx_data == 8'h00);
      6'd14:   hdr_ok = (rx_data == 8'h45);
      6'd23:   hdr_ok = (rx_data == 8'h11);
      6'd36:   hdr_ok = (rx_data == LOCAL_PORT[15:8]);
      6'd37:   hdr_ok = (rx_data == LOCAL_PORT[7:0]);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    rx_valid_prev_d = rx_valid;
    byte_cnt_d      = byte_cnt_q;
    mac_uni_d       = mac_uni_q;
    mac_bc_d        = mac_bc_q;
    line_hi_d       = line_hi_q;
    phase_d         = phase_q;
    r_d             = r_q;
    g_d             = g_q;
    col_d           = col_q;
    reached_pix_d   = reached_pix_q;
    pix_valid_d     = 1'b0;
    pix_x_d         = pix_x_q;
    pix_y_d         = pix_y_q;
    pix_data_d      = pix_data_q;
    line_done_d     = 1'b0;
    line_err_d      = 1'b0;
    drop_cnt_d      = drop_cnt_q;
    drop_inc        = 1'b0;
    line_idx        = {line_hi_q, rx_data};

    if (state_q != IDLE && !rx_valid) begin
      // Frame end: only a complete line with a good FCS is committed.
      state_d = IDLE;
      if (state_q == TAIL && fcs_good) begin
        line_done_d = 1'b1;
      end else begin
        drop_inc   = 1'b1;
        line_err_d = reached_pix_q;
      end
    end else if (state_q != IDLE && rx_error) begin
      state_d = DROP;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && !rx_valid_prev_q) begin
            state_d       = PREAMBLE;
            reached_pix_d = 1'b0;
          end
        end
        PREAMBLE: begin
          if (rx_data == 8'hD5) begin
            state_d    = HEADER;
            byte_cnt_d = 6'd0;
            mac_uni_d  = 1'b1;
            mac_bc_d   = 1'b1;
          end else if (rx_data != 8'h55) begin
            state_d = DROP;
          end
        end
        HEADER: begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q < 6'd6) begin
            mac_uni_d = uni_ok;
            mac_bc_d  = bc_ok;
          end
          if (!hdr_ok) begin
            state_d = DROP;
          end else if (byte_cnt_q == 6'd41) begin
            state_d = LINE_NO;
          end
        end
        LINE_NO: begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q == 6'd42) begin
            line_hi_d = rx_data;
          end else if (line_idx >= V_LIM) begin
            state_d = DROP;
          end else begin
            pix_y_d       = line_idx[11:0];
            state_d       = PIXEL;
            phase_d       = 2'd0;
            col_d         = 12'd0;
            reached_pix_d = 1'b1;
          end
        end
        PIXEL: begin
          case (phase_q)
            2'd0: begin
              r_d     = rx_data;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = rx_data;
              phase_d = 2'd2;
            end
            default: begin
              pix_valid_d = 1'b1;
              pix_x_d     = col_q;
              pix_data_d  = {r_q, g_q, rx_data};
              phase_d     = 2'd0;
              col_d       = col_q + 12'd1;
              if (col_q == X_LAST) begin
                state_d = TAIL;
              end
            end
          endcase
        end
        default: ;
      endcase
    end

    if (drop_inc && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // rx_valid_prev resets high so a frame already in flight at reset release is skipped.
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      rx_valid_prev_q <= 1'b1;
      byte_cnt_q      <= 6'd0;
      mac_uni_q       <= 1'b0;
      mac_bc_q        <= 1'b0;
      line_hi_q       <= 8'h00;
      phase_q         <= 2'd0;
      r_q             <= 8'h00;
      g_q             <= 8'h00;
      col_q           <= 12'd0;
      reached_pix_q   <= 1'b0;
      pix_valid_q     <= 1'b0;
      pix_x_q         <= 12'd0;
      pix_y_q         <= 12'd0;
      pix_data_q      <= 24'h0;
      line_done_q     <= 1'b0;
      line_err_q      <= 1'b0;
      drop_cnt_q      <= 16'd0;
    end else begin
      state_q         <= state_d;
      rx_valid_prev_q <= rx_valid_prev_d;
      byte_cnt_q      <= byte_cnt_d;
      mac_uni_q       <= mac_uni_d;
      mac_bc_q        <= mac_bc_d;
      line_hi_q       <= line_hi_d;
      phase_q         <= phase_d;
      r_q             <= r_d;
      g_q             <= g_d;
      col_q           <= col_d;
      reached_pix_q   <= reached_pix_d;
      pix_valid_q     <= pix_valid_d;
      pix_x_q         <= pix_x_d;
      pix_y_q         <= pix_y_d;
      pix_data_q      <= pix_data_d;
      line_done_q     <= line_done_d;
      line_err_q      <= line_err_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;
  assign line_done = line_done_q;
  assign line_err  = line_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
